// File: rtl/bcd_result_engine.sv
// Digit-serial packed-BCD add/subtract engine returning magnitude and sign to the calculator controller.
// Optional saturating overflow flag on add is enabled by defining BCD_ENGINE_OVF_EN.
module bcd_result_engine #(
    parameter int          DIGITS  = 10,
    parameter logic [1:0]  RES_SEL = 2'b11,
    localparam int         W       = 4 * DIGITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   display_sel,
    input  logic         op,
    input  logic [W-1:0] S1,
    input  logic [W-1:0] S2,
    output logic [W-1:0] result,
    output logic         sign,
    output logic         busy,
    output logic         done
`ifdef BCD_ENGINE_OVF_EN
    ,
    output logic         overflow
`endif
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, NEG, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d;
    logic           neg_q, neg_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   result_q, result_d;
    logic           sign_q, sign_d;
    logic [1:0]     prev_sel_q, prev_sel_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   shadow_q, shadow_d;
    logic           op_q, op_d;
`ifdef BCD_ENGINE_OVF_EN
    logic           ovf_q, ovf_d;
    logic           overflow_q, overflow_d;
`endif

    logic [3:0]     step_x, step_y;
    logic [4:0]     step;
    logic           last;
    logic           start;

    function automatic logic [W-1:0] clamp_digits(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Returns {carry_out, digit}.
    function automatic logic [4:0] bcd_digit(input logic [3:0] x, input logic [3:0] y,
                                             input logic cin);
        logic [4:0] s;
        s = {1'b0, x} + {1'b0, y} + {4'd0, cin};
        if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
        return {1'b0, s[3:0]};
    endfunction

`ifdef BCD_ENGINE_OVF_EN
    function automatic logic [W-1:0] saturate(input logic [W-1:0] v, input logic ovf);
        logic [W-1:0] r;
        r = v;
        if (ovf) begin
            for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction
`endif

    assign start = (display_sel == RES_SEL) && (prev_sel_q != RES_SEL);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        neg_d      = neg_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        sign_d     = sign_q;
        prev_sel_d = display_sel;
        a_d        = a_q;
        b_d        = b_q;
        shadow_d   = shadow_q;
        op_d       = op_q;
`ifdef BCD_ENGINE_OVF_EN
        ovf_d      = ovf_q;
        overflow_d = overflow_q;
`endif

        // NEG reuses the adder as 0 + (9 - s) + c to negate the shadow in place.
        step_x = (state_q == NEG) ? 4'd0 : a_q[3:0];
        if (state_q == NEG)  step_y = 4'd9 - shadow_q[3:0];
        else if (op_q)       step_y = 4'd9 - b_q[3:0];
        else                 step_y = b_q[3:0];
        step = bcd_digit(step_x, step_y, carry_q);
        last = (cnt_q == CW'(DIGITS - 1));

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = clamp_digits(S1);
                    b_d     = clamp_digits(S2);
                    op_d    = op;
                    carry_d = op;
                    cnt_d   = '0;
                    neg_d   = 1'b0;
                    busy_d  = 1'b1;
`ifdef BCD_ENGINE_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
                shadow_d = {step[3:0], shadow_q[W-1:4]};
                a_d      = a_q >> 4;
                b_d      = b_q >> 4;
                carry_d  = step[4];
                cnt_d    = cnt_q + 1'b1;
                if (last) begin
                    cnt_d = '0;
                    if (op_q && !step[4]) begin
                        carry_d = 1'b1;
                        neg_d   = 1'b1;
                        state_d = NEG;
                    end else begin
                        state_d = DONE;
                    end
`ifdef BCD_ENGINE_OVF_EN
                    ovf_d = !op_q && step[4];
`endif
                end
            end
            NEG: begin
                shadow_d = {step[3:0], shadow_q[W-1:4]};
                carry_d  = step[4];
                cnt_d    = cnt_q + 1'b1;
                if (last) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef BCD_ENGINE_OVF_EN
                result_d   = saturate(shadow_q, ovf_q);
                overflow_d = ovf_q;
`else
                result_d   = shadow_q;
`endif
                sign_d  = neg_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            neg_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            sign_q     <= 1'b0;
            prev_sel_q <= 2'b00;
`ifdef BCD_ENGINE_OVF_EN
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            neg_q      <= neg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            sign_q     <= sign_d;
            prev_sel_q <= prev_sel_d;
`ifdef BCD_ENGINE_OVF_EN
            ovf_q      <= ovf_d;
            overflow_q <= overflow_d;
`endif
        end
    end

    // Operand and working registers are fully rewritten before use, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q      <= a_d;
        b_q      <= b_d;
        shadow_q <= shadow_d;
        op_q     <= op_d;
    end

    assign result = result_q;
    assign sign   = sign_q;
    assign busy   = busy_q;
    assign done   = done_q;
`ifdef BCD_ENGINE_OVF_EN
    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_bcd_result_engine.sv
// Directed self-checking bench for bcd_result_engine: vector table plus protocol/reset sequences.
// Also builds with BCD_ENGINE_OVF_EN defined, where the overflow port is connected and checked.
module tb_bcd_result_engine;

    logic        clk;
    logic        reset;
    logic [1:0]  display_sel;
    logic        op_i;
    logic [39:0] S1, S2;
    logic [39:0] result;
    logic        sign, busy, done;
`ifdef BCD_ENGINE_OVF_EN
    logic        overflow;
`endif

    int tests = 0;
    int fails = 0;

    bcd_result_engine dut (
        .clk         (clk),
        .reset       (reset),
        .display_sel (display_sel),
        .op          (op_i),
        .S1          (S1),
        .S2          (S2),
        .result      (result),
        .sign        (sign),
        .busy        (busy),
        .done        (done)
`ifdef BCD_ENGINE_OVF_EN
        ,
        .overflow    (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] s1;
        logic [39:0] s2;
        logic        op;
        logic [39:0] res;
        logic        sgn;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns just after start edge k (#1 past it).
    task automatic start_op(input logic [39:0] s1, input logic [39:0] s2, input logic o);
        @(negedge clk);
        S1 = s1; S2 = s2; op_i = o; display_sel = 2'b01;
        @(negedge clk);
        display_sel = 2'b11;
        @(posedge clk);
        #1;
    endtask

    // Runs ncyc cycles after a start; records first done latency and total done pulses.
    // If edge_at > 0, a fresh 01->11 display_sel edge lands on edge k+edge_at.
    task automatic run_cycles(input int ncyc, input int edge_at, output int lat, output int pulses);
        lat = 0;
        pulses = 0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (edge_at > 0 && n == edge_at - 4) display_sel = 2'b01;
            if (edge_at > 0 && n == edge_at) begin
                display_sel = 2'b11;
                S1 = 40'h100; S2 = 40'h1; op_i = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (lat == 0) lat = n;
            end
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat, pulses;

        vecs[0] = '{40'h0000000123, 40'h0000000877, 1'b0, 40'h0000001000, 1'b0, 1'b0, 11};
        vecs[1] = '{40'h0000000005, 40'h0000000008, 1'b1, 40'h0000000003, 1'b1, 1'b0, 21};
        vecs[2] = '{40'h0000000008, 40'h0000000005, 1'b1, 40'h0000000003, 1'b0, 1'b0, 11};
        vecs[3] = '{40'h0000000042, 40'h0000000042, 1'b1, 40'h0000000000, 1'b0, 1'b0, 11};
`ifdef BCD_ENGINE_OVF_EN
        vecs[4] = '{40'h9999999999, 40'h0000000001, 1'b0, 40'h9999999999, 1'b0, 1'b1, 11};
`else
        vecs[4] = '{40'h9999999999, 40'h0000000001, 1'b0, 40'h0000000000, 1'b0, 1'b1, 11};
`endif
        vecs[5] = '{40'h0000000007, 40'h0000000002, 1'b0, 40'h0000000009, 1'b0, 1'b0, 11};
        vecs[6] = '{40'h000000000F, 40'h0000000001, 1'b0, 40'h0000000010, 1'b0, 1'b0, 11};
        vecs[7] = '{40'h0000000000, 40'h0000001234, 1'b1, 40'h0000001234, 1'b1, 1'b0, 21};
        vecs[8] = '{40'h5000000000, 40'h4999999999, 1'b0, 40'h9999999999, 1'b0, 1'b0, 11};
        vecs[9] = '{40'h0000001000, 40'h0000000001, 1'b1, 40'h0000000999, 1'b0, 1'b0, 11};

        reset = 1'b1;
        display_sel = 2'b00;
        op_i = 1'b0;
        S1 = '0;
        S2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", 64'(result), 64'h0);
        check("rst_sign", 64'(sign), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
`ifdef BCD_ENGINE_OVF_EN
        check("rst_ovf", 64'(overflow), 64'h0);
`endif
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].s1, vecs[i].s2, vecs[i].op);
            check($sformatf("v%0d_busy", i), 64'(busy), 64'h1);
            wait_done(lat);
            check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_res", i), 64'(result), 64'(vecs[i].res));
            check($sformatf("v%0d_sign", i), 64'(sign), 64'(vecs[i].sgn));
            check($sformatf("v%0d_busy_end", i), 64'(busy), 64'h0);
`ifdef BCD_ENGINE_OVF_EN
            check($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].ovf));
`endif
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), 64'(done), 64'h0);
        end

        // display_sel held at RES_SEL for 40 cycles starts exactly once.
        start_op(40'h1, 40'h2, 1'b0);
        run_cycles(40, 0, lat, pulses);
        check("hold_pulses", 64'(pulses), 64'h1);
        check("hold_lat", 64'(lat), 64'd11);
        check("hold_res", 64'(result), 64'h3);

        // A new start edge at cycle 5 of a negative subtraction is ignored.
        start_op(40'h5, 40'h8, 1'b1);
        run_cycles(40, 5, lat, pulses);
        check("busy_edge_pulses", 64'(pulses), 64'h1);
        check("busy_edge_lat", 64'(lat), 64'd21);
        check("busy_edge_res", 64'(result), 64'h3);
        check("busy_edge_sign", 64'(sign), 64'h1);

        // Reset mid-run after a completed 7+2.
        start_op(40'h7, 40'h2, 1'b0);
        wait_done(lat);
        check("pre_rst_res", 64'(result), 64'h9);
        start_op(40'h100, 40'h200, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        display_sel = 2'b01;
        #1;
        check("midrst_res", 64'(result), 64'h0);
        check("midrst_busy", 64'(busy), 64'h0);
        check("midrst_done", 64'(done), 64'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("midrst_no_done", 64'(pulses), 64'h0);
        check("midrst_res_hold", 64'(result), 64'h0);
        start_op(40'h100, 40'h200, 1'b0);
        wait_done(lat);
        check("post_rst_lat", 64'(lat), 64'd11);
        check("post_rst_res", 64'(result), 64'h300);
        check("post_rst_sign", 64'(sign), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
